// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : CPU-side initiator for a single-port memory with a 1-cycle
//            registered read. Arbitrates instruction fetches against LD/SD
//            data accesses (data wins) and, for an MVI fetch, reads the
//            following immediate word so the CPU gets instr+imm in one
//            handshake.
// Ports    : Clock, Resetn        - clock, async active-low reset
//            fetch_req/fetch_pc   - fetch request (level) and address
//            fetch_ack            - 1-cycle pulse, instr/imm/imm_valid valid
//            instr/imm/imm_valid  - fetched instruction, immediate, MVI flag
//            dreq/dwe/daddr/dwdata- data request (level), store flag, addr, data
//            dack/drdata          - 1-cycle pulse, load data
//            busy                 - high whenever the FSM is not idle
//            mem_addr/mem_data/mem_wr_en - registered memory port outputs
//            mem_q                - memory read data (1 cycle after mem_addr)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 5,
  parameter int          OPC_W   = 4,
  parameter logic [OPC_W-1:0] MVI_OPC = 4'b1111
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic              imm_valid,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dack,
  output logic [DATA_W-1:0] drdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_C  = 3'd2;
  localparam logic [2:0] S_IMM_A = 3'd3;
  localparam logic [2:0] S_IMM_C = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              is_fetch_q, is_fetch_d;   // kind of the accepted read
  logic              fetch_ack_q, fetch_ack_d;
  logic              dack_q, dack_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              imm_valid_q, imm_valid_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wr_en_q, mem_wr_en_d;

  logic              is_mvi;
  assign is_mvi = (mem_q[DATA_W-1 -: OPC_W] == MVI_OPC);

  // State register plus all registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      is_fetch_q  <= 1'b0;
      fetch_ack_q <= 1'b0;
      dack_q      <= 1'b0;
      instr_q     <= '0;
      imm_q       <= '0;
      imm_valid_q <= 1'b0;
      drdata_q    <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wr_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_fetch_q  <= is_fetch_d;
      fetch_ack_q <= fetch_ack_d;
      dack_q      <= dack_d;
      instr_q     <= instr_d;
      imm_q       <= imm_d;
      imm_valid_q <= imm_valid_d;
      drdata_q    <= drdata_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wr_en_q <= mem_wr_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dreq)           state_d = dwe ? S_WR : S_RD_A;
        else if (fetch_req) state_d = S_RD_A;
      end
      S_RD_A:  state_d = S_RD_C;
      S_RD_C:  state_d = (is_fetch_q && is_mvi) ? S_IMM_A : S_ACK;
      S_IMM_A: state_d = S_IMM_C;
      S_IMM_C: state_d = S_ACK;
      S_WR:    state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output.
  // Ack pulses are only raised on the transition into ACK, so the default
  // of zero ends them after exactly one cycle.
  always_comb begin
    is_fetch_d  = is_fetch_q;
    fetch_ack_d = 1'b0;
    dack_d      = 1'b0;
    instr_d     = instr_q;
    imm_d       = imm_q;
    imm_valid_d = imm_valid_q;
    drdata_d    = drdata_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wr_en_d = mem_wr_en_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (dreq) begin
          is_fetch_d  = 1'b0;
          mem_addr_d  = daddr;
          if (dwe) begin
            mem_data_d  = dwdata;
            mem_wr_en_d = 1'b1;
          end else begin
            mem_wr_en_d = 1'b0;
          end
        end else if (fetch_req) begin
          is_fetch_d  = 1'b1;
          mem_addr_d  = fetch_pc;
          mem_wr_en_d = 1'b0;
        end
      end
      S_RD_C: begin
        if (is_fetch_q) begin
          instr_d = mem_q;
          if (is_mvi) begin
            // mem_addr still holds the fetch pc; next word wraps naturally
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end else begin
            imm_d       = '0;
            imm_valid_d = 1'b0;
            fetch_ack_d = 1'b1;
          end
        end else begin
          drdata_d = mem_q;
          dack_d   = 1'b1;
        end
      end
      S_IMM_C: begin
        imm_d       = mem_q;
        imm_valid_d = 1'b1;
        fetch_ack_d = 1'b1;
      end
      S_WR: begin
        mem_wr_en_d = 1'b0;
        dack_d      = 1'b1;
      end
      default: ;
    endcase
  end

  assign fetch_ack = fetch_ack_q;
  assign dack      = dack_q;
  assign instr     = instr_q;
  assign imm       = imm_q;
  assign imm_valid = imm_valid_q;
  assign drdata    = drdata_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wr_en = mem_wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl: directed vector table,
//            contention and reset-in-flight sequences, then random single
//            transactions checked against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        fetch_req = 1'b0;
  logic [4:0]  fetch_pc = '0;
  logic        fetch_ack;
  logic [15:0] instr, imm;
  logic        imm_valid;
  logic        dreq = 1'b0, dwe = 1'b0;
  logic [4:0]  daddr = '0;
  logic [15:0] dwdata = '0;
  logic        dack;
  logic [15:0] drdata;
  logic        busy;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wr_en;
  logic [15:0] mem_q = '0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [32];        // the memory device attached to the DUT
  logic [15:0] model_mem [32];  // reference model's view of memory

  mem_access_ctrl dut (
    .Clock(Clock), .Resetn(Resetn),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack),
    .instr(instr), .imm(imm), .imm_valid(imm_valid),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
    .mem_q(mem_q)
  );

  always #5 Clock = ~Clock;

  // Single-port memory, registered read (old data on same-cycle write)
  always @(posedge Clock) begin
    mem_q <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] = mem_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One transaction started in an IDLE cycle (cycle 0) at a negedge.
  task automatic do_txn(input bit is_data, input bit we, input logic [4:0] a,
                        input logic [15:0] wd, output int lat, output int wr_pulses,
                        output logic [4:0] wr_addr, output logic [4:0] addr_c3);
    int cyc;
    bit got;
    int other;
    int busy_low;
    cyc = 0; got = 0; other = 0; busy_low = 0;
    lat = -1; wr_pulses = 0; wr_addr = '0; addr_c3 = '0;
    if (is_data) begin dreq = 1'b1; dwe = we; daddr = a; dwdata = wd; end
    else begin fetch_req = 1'b1; fetch_pc = a; end
    while (!got && cyc < 20) begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1) begin
        // request already accepted; these must be ignored from now on
        daddr = 5'($urandom); dwdata = 16'($urandom); fetch_pc = 5'($urandom);
        dwe = 1'($urandom);
      end
      if (mem_wr_en) begin wr_pulses++; wr_addr = mem_addr; end
      if (cyc == 3) addr_c3 = mem_addr;
      if (!busy) busy_low++;
      if (is_data ? fetch_ack : dack) other++;
      if (is_data ? dack : fetch_ack) begin got = 1; lat = cyc; end
    end
    dreq = 1'b0; fetch_req = 1'b0; dwe = 1'b0;
    chk("wrong_ack", 64'(other), 64'd0);
    chk("busy_during", 64'(busy_low), 64'd0);
    @(negedge Clock);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("wr_en_idle", 64'(mem_wr_en), 64'd0);
  endtask

  typedef struct {
    bit          is_data;
    bit          we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    bit          p0;
    logic [4:0]  pa0;
    logic [15:0] pd0;
    bit          p1;
    logic [4:0]  pa1;
    logic [15:0] pd1;
    int          lat;
    logic [15:0] ei;
    logic [15:0] eimm;
    bit          eiv;
    logic [15:0] erd;
    int          ewr;
    logic [4:0]  ea3;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, wrp;
    logic [4:0] wra, a3;
    logic [15:0] e_instr, e_imm, e_rd;
    logic e_iv;
    int dack_cyc, fack_cyc;

    for (int i = 0; i < 32; i++) begin mem[i] = '0; model_mem[i] = '0; end

    vecs[0] = '{1'b0,1'b0,5'd4, 16'h0,   1'b1,5'd4, 16'h0240, 1'b0,5'd0,16'h0,    3, 16'h0240,16'h0,   1'b0,16'h0,   0, 5'd4};
    vecs[1] = '{1'b0,1'b0,5'd0, 16'h0,   1'b1,5'd0, 16'hF000, 1'b1,5'd1,16'h0002, 5, 16'hF000,16'h0002,1'b1,16'h0,   0, 5'd1};
    vecs[2] = '{1'b0,1'b0,5'd31,16'h0,   1'b1,5'd31,16'hF200, 1'b1,5'd0,16'h0003, 5, 16'hF200,16'h0003,1'b1,16'h0,   0, 5'd0};
    vecs[3] = '{1'b1,1'b1,5'd3, 16'h0007,1'b0,5'd0, 16'h0,    1'b0,5'd0,16'h0,    2, 16'h0,   16'h0,   1'b0,16'h0,   1, 5'd3};
    vecs[4] = '{1'b1,1'b0,5'd3, 16'h0,   1'b0,5'd0, 16'h0,    1'b0,5'd0,16'h0,    3, 16'h0,   16'h0,   1'b0,16'h0007,0, 5'd3};
    vecs[5] = '{1'b0,1'b0,5'd4, 16'h0,   1'b0,5'd0, 16'h0,    1'b0,5'd0,16'h0,    3, 16'h0240,16'h0,   1'b0,16'h0,   0, 5'd4};
    vecs[6] = '{1'b1,1'b0,5'd0, 16'h0,   1'b0,5'd0, 16'h0,    1'b0,5'd0,16'h0,    3, 16'h0,   16'h0,   1'b0,16'h0003,0, 5'd0};

    // ---- reset state
    repeat (2) @(negedge Clock);
    chk("reset_outputs", {44'd0, fetch_ack, dack, imm_valid, busy, mem_wr_en, mem_addr, 11'd0},
        64'd0);
    chk("reset_data", {instr, imm, drdata, mem_data}, 64'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // ---- directed vector table
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].p0) mem[vecs[v].pa0] = vecs[v].pd0;
      if (vecs[v].p1) mem[vecs[v].pa1] = vecs[v].pd1;
      do_txn(vecs[v].is_data, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, wrp, wra, a3);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
      chk($sformatf("v%0d_wr_pulses", v), 64'(wrp), 64'(vecs[v].ewr));
      if (vecs[v].ewr != 0) chk($sformatf("v%0d_wr_addr", v), 64'(wra), 64'(vecs[v].addr));
      if (!(vecs[v].is_data && vecs[v].we))
        chk($sformatf("v%0d_addr_cyc3", v), 64'(a3), 64'(vecs[v].ea3));
      if (!vecs[v].is_data)
        chk($sformatf("v%0d_fetch", v), {15'd0, instr, imm, imm_valid},
            {15'd0, vecs[v].ei, vecs[v].eimm, vecs[v].eiv});
      else if (!vecs[v].we)
        chk($sformatf("v%0d_drdata", v), 64'(drdata), 64'(vecs[v].erd));
    end
    chk("store_in_mem", 64'(mem[3]), 64'h0007);

    // ---- contention: LD addr 3 and fetch pc 2 raised together
    mem[2] = 16'h0123;
    dreq = 1'b1; dwe = 1'b0; daddr = 5'd3; fetch_req = 1'b1; fetch_pc = 5'd2;
    dack_cyc = -1; fack_cyc = -1;
    for (int c = 1; c <= 30 && fack_cyc < 0; c++) begin
      @(negedge Clock);
      if (dack) begin dack_cyc = c; dreq = 1'b0; end
      if (fetch_ack) begin fack_cyc = c; fetch_req = 1'b0; end
    end
    dreq = 1'b0; fetch_req = 1'b0;
    chk("contend_dack_cyc", 64'(dack_cyc), 64'd3);
    chk("contend_fack_cyc", 64'(fack_cyc), 64'd7);
    chk("contend_drdata", 64'(drdata), 64'h0007);
    chk("contend_instr", {instr, imm, 15'd0, imm_valid}, {16'h0123, 16'h0, 16'h0});
    @(negedge Clock);

    // ---- random transactions against a word-level model
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'hF;
      mem[i] = w; model_mem[i] = w;
    end
    e_instr = 16'h0123; e_imm = 16'h0; e_iv = 1'b0; e_rd = 16'h0007;
    for (int t = 0; t < 60; t++) begin
      int kind, exp_lat;
      logic [4:0] a;
      logic [15:0] wd;
      kind = $urandom_range(0, 2);
      a = 5'($urandom);
      wd = 16'($urandom);
      if (kind == 0) begin
        exp_lat = 2;
        model_mem[a] = wd;
      end else if (kind == 1) begin
        exp_lat = 3;
        e_rd = model_mem[a];
      end else begin
        e_instr = model_mem[a];
        if (e_instr[15:12] == 4'hF) begin
          exp_lat = 5; e_iv = 1'b1; e_imm = model_mem[(a + 1) % 32];
        end else begin
          exp_lat = 3; e_iv = 1'b0; e_imm = 16'h0;
        end
      end
      do_txn(kind != 2, kind == 0, a, wd, lat, wrp, wra, a3);
      chk($sformatf("r%0d_latency", t), 64'(lat), 64'(exp_lat));
      chk($sformatf("r%0d_wr_pulses", t), 64'(wrp), (kind == 0) ? 64'd1 : 64'd0);
      chk($sformatf("r%0d_held", t), {instr, imm, drdata, 15'd0, imm_valid},
          {e_instr, e_imm, e_rd, 15'd0, e_iv});
    end
    for (int i = 0; i < 32; i++)
      chk($sformatf("mem_%0d", i), 64'(mem[i]), 64'(model_mem[i]));

    // ---- reset during IMM_C
    mem[0] = 16'hF000; mem[1] = 16'h0002; mem[4] = 16'h0240;
    fetch_req = 1'b1; fetch_pc = 5'd0;
    repeat (4) @(negedge Clock);
    Resetn = 1'b0;
    #1;
    chk("midrst_outputs", {44'd0, fetch_ack, dack, imm_valid, busy, mem_wr_en, mem_addr, 11'd0},
        64'd0);
    chk("midrst_data", {instr, imm, drdata, mem_data}, 64'd0);
    fetch_req = 1'b0;
    wrp = 0;
    repeat (3) begin
      @(negedge Clock);
      if (fetch_ack || dack) wrp++;
    end
    Resetn = 1'b1;
    @(negedge Clock);
    if (fetch_ack || dack) wrp++;
    chk("midrst_no_ack", 64'(wrp), 64'd0);
    do_txn(1'b0, 1'b0, 5'd4, 16'h0, lat, wrp, wra, a3);
    chk("postrst_latency", 64'(lat), 64'd3);
    chk("postrst_fetch", {15'd0, instr, imm, imm_valid}, {15'd0, 16'h0240, 16'h0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
